// File: rtl/rv_muldiv_unit_pkg.sv
// Shared constants, op encodings and FSM state type for the RV32M
// multiply/divide unit.
package rv_muldiv_unit_pkg;

  localparam int XLEN       = 32;
  localparam int HART_ID_W  = 3;
  localparam int REG_ADDR_W = 5;
  localparam int CNT_W      = $clog2(XLEN);

  localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

  localparam logic [2:0] MULDIV_OP_MUL    = 3'd0;
  localparam logic [2:0] MULDIV_OP_MULH   = 3'd1;
  localparam logic [2:0] MULDIV_OP_MULHSU = 3'd2;
  localparam logic [2:0] MULDIV_OP_MULHU  = 3'd3;
  localparam logic [2:0] MULDIV_OP_DIV    = 3'd4;
  localparam logic [2:0] MULDIV_OP_DIVU   = 3'd5;
  localparam logic [2:0] MULDIV_OP_REM    = 3'd6;
  localparam logic [2:0] MULDIV_OP_REMU   = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } muldiv_state_t;

endpackage

// File: rtl/rv_muldiv_unit_if.sv
// Issue/completion bus between the pipeline (master) and the muldiv unit.
//
// Handshake: muldiv_start is taken on a rising clk edge only while
// muldiv_busy is 0; op, operands and tags must be valid in that same cycle.
// A start seen while busy is 1 is dropped, never queued. Completion is a
// single-cycle muldiv_done pulse; result and tags are valid in that cycle
// (muldiv_busy is 0 then) and may hold afterwards.
interface rv_muldiv_unit_if;
  import rv_muldiv_unit_pkg::*;

  logic                  muldiv_start;
  logic [2:0]            muldiv_op;
  logic [XLEN-1:0]       muldiv_a;
  logic [XLEN-1:0]       muldiv_b;
  logic [HART_ID_W-1:0]  muldiv_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_rd;
  logic                  muldiv_busy;
  logic                  muldiv_done;
  logic [XLEN-1:0]       muldiv_result;
  logic [HART_ID_W-1:0]  muldiv_done_hart_id;
  logic [REG_ADDR_W-1:0] muldiv_done_rd;

  modport master (
    output muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    input  muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
  );

  modport slave (
    input  muldiv_start, muldiv_op, muldiv_a, muldiv_b, muldiv_hart_id, muldiv_rd,
    output muldiv_busy, muldiv_done, muldiv_result, muldiv_done_hart_id, muldiv_done_rd
  );

endinterface

// File: rtl/rv_muldiv_unit_sign_fix.sv
// Sign handling around the unsigned core: operand magnitudes and the
// result-negate flag at issue time, and the final two's-complement fixup.
module rv_muldiv_unit_sign_fix
  import rv_muldiv_unit_pkg::*;
(
  input  logic [2:0]        op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   mag_a,
  output logic [XLEN-1:0]   mag_b,
  output logic              neg,
  input  logic [2*XLEN-1:0] raw,
  input  logic              raw_neg,
  output logic [2*XLEN-1:0] fixed
);

  logic a_signed, b_signed, a_neg, b_neg;

  // Magnitudes and the sign the final result must carry.
  always_comb begin
    // MUL keeps the low half, which is the same for any signedness.
    a_signed = op[2] ? ~op[0] : ((op[1:0] == 2'd1) || (op[1:0] == 2'd2));
    b_signed = op[2] ? ~op[0] : (op[1:0] == 2'd1);
    a_neg    = a_signed & a[XLEN-1];
    b_neg    = b_signed & b[XLEN-1];
    mag_a    = a_neg ? -a : a;
    mag_b    = b_neg ? -b : b;
    if (!op[2]) begin
      neg = a_neg ^ b_neg;
    end else if (op[1]) begin
      neg = a_neg;
    end else begin
      // Divide by zero must come out all-ones, so the quotient stays positive.
      neg = (a_neg ^ b_neg) & (b != '0);
    end
  end

  // Final negation of the raw unsigned result.
  always_comb begin
    fixed = raw_neg ? -raw : raw;
  end

endmodule

// File: rtl/rv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiplier and restoring
// divider, one result bit per cycle, single-cycle done pulse with tags.
// Optional feature macro: MULDIV_FAST_PATH_EN (zero-operand multiply,
// divide-by-zero and signed overflow skip RUN; multiply ends early once the
// remaining multiplier is zero).
module rv_muldiv_unit
  import rv_muldiv_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  rv_muldiv_unit_if.slave bus,
  output muldiv_state_t   dbg_state
);

  muldiv_state_t state_q, state_d;
  logic accept;

  logic [CNT_W-1:0]      cnt_q;
  logic [2:0]            op_q;
  logic [HART_ID_W-1:0]  hart_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  neg_q;
  // Multiply: acc = product, opnd = shifted multiplicand.
  // Divide:   acc = {remainder, quotient/dividend}, opnd low half = divisor.
  logic [2*XLEN-1:0]     acc_q, opnd_q;
  logic [XLEN-1:0]       mplier_q;

  logic                  done_q;
  logic [XLEN-1:0]       result_q;
  logic [HART_ID_W-1:0]  done_hart_q;
  logic [REG_ADDR_W-1:0] done_rd_q;

  logic [XLEN-1:0]   sf_mag_a, sf_mag_b;
  logic              sf_neg;
  logic [2*XLEN-1:0] raw_sel, fixed;
  logic [XLEN-1:0]   final_res;

  logic [XLEN:0]     rem_shift, diff;
  logic [2*XLEN-1:0] acc_step, opnd_step;
  logic [XLEN-1:0]   mplier_step;

  logic fast_start, fast_div0, mul_early;

  rv_muldiv_unit_sign_fix u_sign_fix (
    .op      (bus.muldiv_op),
    .a       (bus.muldiv_a),
    .b       (bus.muldiv_b),
    .mag_a   (sf_mag_a),
    .mag_b   (sf_mag_b),
    .neg     (sf_neg),
    .raw     (raw_sel),
    .raw_neg (neg_q),
    .fixed   (fixed)
  );

  // One iteration of the multiply or divide core.
  always_comb begin
    rem_shift   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    diff        = rem_shift - {1'b0, opnd_q[XLEN-1:0]};
    mplier_step = mplier_q >> 1;
    opnd_step   = opnd_q;
    acc_step    = acc_q;
    if (op_q[2]) begin
      if (!diff[XLEN]) begin
        acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
        acc_step = {rem_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
    end else begin
      acc_step  = mplier_q[0] ? (acc_q + opnd_q) : acc_q;
      opnd_step = opnd_q << 1;
    end
  end

  // Fast-path decisions (constant zero in the baseline build).
  always_comb begin
    fast_start = 1'b0;
    fast_div0  = 1'b0;
    mul_early  = 1'b0;
`ifdef MULDIV_FAST_PATH_EN
    if (bus.muldiv_op[2]) begin
      fast_div0  = (bus.muldiv_b == '0);
      fast_start = fast_div0 ||
                   (!bus.muldiv_op[0] && (bus.muldiv_a == SIGNED_MIN) && (bus.muldiv_b == '1));
    end else begin
      fast_start = (bus.muldiv_a == '0) || (bus.muldiv_b == '0);
    end
    mul_early = !op_q[2] && (mplier_step == '0);
`endif
  end

  // Select the half of the accumulator that becomes the architectural result.
  always_comb begin
    if (op_q[2]) begin
      raw_sel = {{XLEN{1'b0}}, (op_q[1] ? acc_q[2*XLEN-1:XLEN] : acc_q[XLEN-1:0])};
    end else begin
      raw_sel = acc_q;
    end
    final_res = (op_q[2] || (op_q[1:0] == 2'd0)) ? fixed[XLEN-1:0] : fixed[2*XLEN-1:XLEN];
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // FSM next state; a start is accepted in IDLE and DONE alike.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.muldiv_start) begin
          accept  = 1'b1;
          state_d = fast_start ? S_DONE : S_RUN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if ((cnt_q == CNT_W'(XLEN-1)) || mul_early) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Operand capture, iteration and result/tag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      op_q        <= '0;
      hart_q      <= '0;
      rd_q        <= '0;
      neg_q       <= 1'b0;
      acc_q       <= '0;
      opnd_q      <= '0;
      mplier_q    <= '0;
      done_q      <= 1'b0;
      result_q    <= '0;
      done_hart_q <= '0;
      done_rd_q   <= '0;
    end else begin
      // DONE is the finalisation cycle; the pulse is registered out of it.
      done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        result_q    <= final_res;
        done_hart_q <= hart_q;
        done_rd_q   <= rd_q;
      end
      if (accept) begin
        op_q     <= bus.muldiv_op;
        hart_q   <= bus.muldiv_hart_id;
        rd_q     <= bus.muldiv_rd;
        neg_q    <= sf_neg;
        cnt_q    <= '0;
        mplier_q <= sf_mag_b;
        if (bus.muldiv_op[2]) begin
          // A fast divide-by-zero preloads the state full iteration would reach.
          acc_q  <= fast_div0 ? {sf_mag_a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, sf_mag_a};
          opnd_q <= {{XLEN{1'b0}}, sf_mag_b};
        end else begin
          acc_q  <= '0;
          opnd_q <= {{XLEN{1'b0}}, sf_mag_a};
        end
      end else if (state_q == S_RUN) begin
        acc_q    <= acc_step;
        opnd_q   <= opnd_step;
        mplier_q <= mplier_step;
        cnt_q    <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign bus.muldiv_busy         = (state_q == S_RUN);
  assign bus.muldiv_done         = done_q;
  assign bus.muldiv_result       = result_q;
  assign bus.muldiv_done_hart_id = done_hart_q;
  assign bus.muldiv_done_rd      = done_rd_q;
  assign dbg_state               = state_q;

endmodule

// File: tb/tb_rv_muldiv_unit.sv
// Directed and randomised bench for rv_muldiv_unit; latency expectations
// follow MULDIV_FAST_PATH_EN when it is defined for the build.
module tb_rv_muldiv_unit;
  import rv_muldiv_unit_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  muldiv_state_t dbg_state;
  int            checks = 0;
  int            failures = 0;

  rv_muldiv_unit_if bus();

  rv_muldiv_unit dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference result built from native arithmetic.
  function automatic logic [31:0] golden(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    longint sa, sb, ub;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ub = {32'b0, b};
    case (op)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Expected start-to-done latency in cycles.
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] mb;
    int fast_lat;
    int n;
    n = 0;
    mb = (op == 3'd1 && b[31]) ? -b : b;
    for (int i = 0; i < 32; i++) if (mb[i]) n = i + 1;
    if (!op[2]) fast_lat = (a == 0 || b == 0) ? 1 : n + 1;
    else if (b == 0) fast_lat = 1;
    else if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) fast_lat = 1;
    else fast_lat = 33;
`ifdef MULDIV_FAST_PATH_EN
    return fast_lat;
`else
    return (fast_lat > 0) ? 33 : 33;
`endif
  endfunction

  // Driver: present one start pulse; returns #1 after the sampling edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [HART_ID_W-1:0] hid, input logic [REG_ADDR_W-1:0] rd);
    @(negedge clk);
    bus.muldiv_start   = 1'b1;
    bus.muldiv_op      = op;
    bus.muldiv_a       = a;
    bus.muldiv_b       = b;
    bus.muldiv_hart_id = hid;
    bus.muldiv_rd      = rd;
    @(posedge clk);
    #1;
    bus.muldiv_start = 1'b0;
  endtask

  // Driver: wait for done (bounded), returning latency and busy observation.
  task automatic wait_done(output int lat, output bit busy_seen, output bit timed_out);
    lat = 0;
    busy_seen = bus.muldiv_busy;
    timed_out = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.muldiv_done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
      busy_seen |= bus.muldiv_busy;
    end
  endtask

  task automatic test_reset();
    bus.muldiv_start = 1'b0; bus.muldiv_op = '0; bus.muldiv_a = '0; bus.muldiv_b = '0;
    bus.muldiv_hart_id = '0; bus.muldiv_rd = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.muldiv_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.muldiv_busy); end
    checks++; if (bus.muldiv_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", bus.muldiv_done); end
    checks++; if (bus.muldiv_result !== 32'h0) begin failures++; $display("FAIL reset_result got=%h exp=0", bus.muldiv_result); end
    checks++; if (bus.muldiv_done_hart_id !== '0 || bus.muldiv_done_rd !== '0) begin
      failures++; $display("FAIL reset_tags got=%h/%h exp=0/0", bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
    checks++; if (dbg_state !== S_IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, S_IDLE); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_mul();
    logic [2:0]  t_op [6] = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd3, 3'd2};
    logic [31:0] t_a  [6] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_b  [6] = '{32'h0, 32'h1234_5678, 32'h2, 32'h2, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] t_r  [6] = '{32'h0, 32'h1234_5678, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    int lat, el; bit bs, to;
    for (int i = 0; i < 6; i++) begin
      issue(t_op[i], t_a[i], t_b[i], HART_ID_W'(i + 1), REG_ADDR_W'(i + 10));
      wait_done(lat, bs, to);
      el = exp_lat(t_op[i], t_a[i], t_b[i]);
      checks++; if (bus.muldiv_result !== t_r[i]) begin failures++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, bus.muldiv_result, t_r[i]); end
      checks++; if (to || lat != el) begin failures++; $display("FAIL mul_latency[%0d] got=%0d exp=%0d", i, lat, el); end
      checks++; if (bs !== (el > 1)) begin failures++; $display("FAIL mul_busy_seen[%0d] got=%b exp=%b", i, bs, el > 1); end
      checks++; if (bus.muldiv_done_hart_id !== HART_ID_W'(i + 1) || bus.muldiv_done_rd !== REG_ADDR_W'(i + 10)) begin
        failures++; $display("FAIL mul_tags[%0d] got=%h/%h exp=%h/%h", i, bus.muldiv_done_hart_id, bus.muldiv_done_rd, HART_ID_W'(i + 1), REG_ADDR_W'(i + 10)); end
      checks++; if (bus.muldiv_busy !== 1'b0) begin failures++; $display("FAIL mul_busy_in_done[%0d] got=%b exp=0", i, bus.muldiv_busy); end
      @(posedge clk); #1;
      checks++; if (bus.muldiv_done !== 1'b0) begin failures++; $display("FAIL mul_done_width[%0d] got=%b exp=0", i, bus.muldiv_done); end
    end
  endtask

  task automatic test_div();
    logic [2:0]  t_op [9] = '{3'd4, 3'd4, 3'd7, 3'd5, 3'd6, 3'd7, 3'd5, 3'd6, 3'd4};
    logic [31:0] t_a  [9] = '{32'h8000_0000, 32'h1, 32'h5, 32'h33, 32'hFFFF_FF9C, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9};
    logic [31:0] t_b  [9] = '{32'hFFFF_FFFF, 32'h0, 32'h0, 32'h8, 32'hFFFF_FFFC, 32'h7, 32'h10, 32'hFFFF_FFFF, 32'h2};
    logic [31:0] t_r  [9] = '{32'h8000_0000, 32'hFFFF_FFFF, 32'h5, 32'h6, 32'h0, 32'h5, 32'h0800_0000, 32'h0, 32'hFFFF_FFFD};
    int lat, el; bit bs, to;
    for (int i = 0; i < 9; i++) begin
      issue(t_op[i], t_a[i], t_b[i], HART_ID_W'(7 - (i % 8)), REG_ADDR_W'(31 - i));
      wait_done(lat, bs, to);
      el = exp_lat(t_op[i], t_a[i], t_b[i]);
      checks++; if (bus.muldiv_result !== t_r[i]) begin failures++; $display("FAIL div_result[%0d] got=%h exp=%h", i, bus.muldiv_result, t_r[i]); end
      checks++; if (to || lat != el) begin failures++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, lat, el); end
      checks++; if (bus.muldiv_done_hart_id !== HART_ID_W'(7 - (i % 8)) || bus.muldiv_done_rd !== REG_ADDR_W'(31 - i)) begin
        failures++; $display("FAIL div_tags[%0d] got=%h/%h", i, bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
      @(posedge clk); #1;
      checks++; if (bus.muldiv_done !== 1'b0) begin failures++; $display("FAIL div_done_width[%0d] got=%b exp=0", i, bus.muldiv_done); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; bit bs, to;
    issue(MULDIV_OP_MUL, 32'd7, 32'd6, 3'd1, 5'd1);
    wait_done(lat, bs, to);
    checks++; if (bus.muldiv_result !== 32'd42) begin failures++; $display("FAIL b2b_first got=%h exp=%h", bus.muldiv_result, 32'd42); end
    // Issue the next op while the first done pulse is still high.
    issue(MULDIV_OP_DIV, 32'hFFFF_FFF9, 32'd2, 3'd2, 5'd2);
    wait_done(lat, bs, to);
    checks++; if (bus.muldiv_result !== 32'hFFFF_FFFD) begin failures++; $display("FAIL b2b_second got=%h exp=%h", bus.muldiv_result, 32'hFFFF_FFFD); end
    checks++; if (to || lat != 33) begin failures++; $display("FAIL b2b_latency got=%0d exp=33", lat); end
    @(posedge clk); #1;
  endtask

  task automatic test_start_in_done();
    int lat; bit bs, to;
    issue(MULDIV_OP_DIVU, 32'h33, 32'h8, 3'd2, 5'd7);
    repeat (32) @(posedge clk);
    #1;
    checks++; if (dbg_state !== S_DONE || bus.muldiv_busy !== 1'b0) begin
      failures++; $display("FAIL sid_state got=%0d/%b exp=%0d/0", dbg_state, bus.muldiv_busy, S_DONE); end
    issue(MULDIV_OP_REMU, 32'h5, 32'h7, 3'd5, 5'd12);
    checks++; if (bus.muldiv_done !== 1'b1 || bus.muldiv_result !== 32'h6) begin
      failures++; $display("FAIL sid_first_done got=%b/%h exp=1/%h", bus.muldiv_done, bus.muldiv_result, 32'h6); end
    checks++; if (bus.muldiv_done_hart_id !== 3'd2 || bus.muldiv_done_rd !== 5'd7) begin
      failures++; $display("FAIL sid_first_tags got=%h/%h exp=2/07", bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
    checks++; if (bus.muldiv_busy !== 1'b1) begin failures++; $display("FAIL sid_accept got=%b exp=1", bus.muldiv_busy); end
    wait_done(lat, bs, to);
    checks++; if (to || lat != 33 || bus.muldiv_result !== 32'h5) begin
      failures++; $display("FAIL sid_second got=%0d/%h exp=33/%h", lat, bus.muldiv_result, 32'h5); end
    checks++; if (bus.muldiv_done_hart_id !== 3'd5 || bus.muldiv_done_rd !== 5'd12) begin
      failures++; $display("FAIL sid_second_tags got=%h/%h exp=5/0c", bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
    @(posedge clk); #1;
  endtask

  task automatic test_busy_ignore();
    int lat, extra; bit bs, to;
    issue(MULDIV_OP_DIVU, 32'h33, 32'h8, 3'd1, 5'd3);
    repeat (5) @(posedge clk);
    issue(MULDIV_OP_MUL, 32'd3, 32'd3, 3'd6, 5'd9);
    wait_done(lat, bs, to);
    checks++; if (to || bus.muldiv_result !== 32'h6) begin failures++; $display("FAIL ignore_result got=%h exp=%h", bus.muldiv_result, 32'h6); end
    checks++; if (bus.muldiv_done_hart_id !== 3'd1 || bus.muldiv_done_rd !== 5'd3) begin
      failures++; $display("FAIL ignore_tags got=%h/%h exp=1/03", bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.muldiv_done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", extra); end
  endtask

  task automatic test_reset_mid();
    int extra;
    issue(MULDIV_OP_DIVU, 32'h1234, 32'h7, 3'd3, 5'd4);
    repeat (10) @(posedge clk);
    #1;
    checks++; if (bus.muldiv_busy !== 1'b1) begin failures++; $display("FAIL rstmid_busy_before got=%b exp=1", bus.muldiv_busy); end
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++; if (bus.muldiv_busy !== 1'b0 || bus.muldiv_done !== 1'b0 || bus.muldiv_result !== 32'h0 ||
                  bus.muldiv_done_hart_id !== '0 || bus.muldiv_done_rd !== '0) begin
      failures++; $display("FAIL rstmid_outputs got=%b/%b/%h/%h/%h exp=0/0/0/0/0", bus.muldiv_busy, bus.muldiv_done,
                           bus.muldiv_result, bus.muldiv_done_hart_id, bus.muldiv_done_rd); end
    @(negedge clk); rst = 1'b0;
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (bus.muldiv_done === 1'b1) extra++;
    end
    checks++; if (extra != 0) begin failures++; $display("FAIL rstmid_done got=%0d exp=0", extra); end
  endtask

  task automatic test_random();
    logic [2:0] op; logic [31:0] a, b, er; logic [HART_ID_W-1:0] hid; logic [REG_ADDR_W-1:0] rd;
    int lat, el; bit bs, to;
    for (int n = 0; n < 256; n++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 5))
        0: a = 32'h0;
        1: a = 32'h8000_0000;
        2: a = 32'hFFFF_FFFF;
        3: a = 32'($urandom_range(0, 20));
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'h0;
        1: b = 32'h8000_0000;
        2: b = 32'hFFFF_FFFF;
        3: b = 32'($urandom_range(0, 20));
        default: b = $urandom;
      endcase
      hid = HART_ID_W'($urandom);
      rd  = REG_ADDR_W'($urandom);
      er  = golden(op, a, b);
      el  = exp_lat(op, a, b);
      issue(op, a, b, hid, rd);
      wait_done(lat, bs, to);
      checks++; if (bus.muldiv_result !== er) begin
        failures++; $display("FAIL rand_result[%0d] op=%0d a=%h b=%h got=%h exp=%h", n, op, a, b, bus.muldiv_result, er); end
      checks++; if (to || lat != el || lat > 33) begin
        failures++; $display("FAIL rand_latency[%0d] op=%0d got=%0d exp=%0d", n, op, lat, el); end
      checks++; if (bus.muldiv_done_hart_id !== hid || bus.muldiv_done_rd !== rd) begin
        failures++; $display("FAIL rand_tags[%0d] got=%h/%h exp=%h/%h", n, bus.muldiv_done_hart_id, bus.muldiv_done_rd, hid, rd); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_back_to_back();
    test_start_in_done();
    test_busy_ignore();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
